// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers.
// One byte per grant, ack pulse on completion, watchdog aborts a transfer whose done never arrives.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        grant,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_done,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_ACK} state_e;

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                any_req;
  logic [PTR_W-1:0]    sel_idx;
  logic [PTR_W:0]      cand;
  logic                wait_timeout;
  logic [PTR_W-1:0]    ptr_after_sel;

  // Search starts at ptr and wraps, so the most recently served requester is considered last.
  always_comb begin
    any_req = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_REQ)) begin
        cand = cand - (PTR_W+1)'(N_REQ);
      end
      if (!any_req && req[cand[PTR_W-1:0]]) begin
        any_req = 1'b1;
        sel_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    wait_timeout  = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);
    ptr_after_sel = (sel_q == PTR_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ack_q         <= '0;
      grant_q       <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      ptr_q         <= '0;
      sel_q         <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      grant_q       <= grant_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      ptr_q         <= ptr_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_done)           state_d = ST_ACK;
        else if (wait_timeout) state_d = ST_IDLE;
      end
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    ack_d         = '0;
    grant_d       = grant_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;
    ptr_d         = ptr_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          sel_d      = sel_idx;
          grant_d    = N_REQ'(1) << sel_idx;
          tx_data_d  = req_data[int'(sel_idx)*DATA_W +: DATA_W];
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_START: cnt_d = '0;
      ST_WAIT: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        if (tx_done) begin
          ack_d = N_REQ'(1) << sel_q;
        end else if (wait_timeout) begin
          timeout_err_d = 1'b1;
          grant_d       = '0;
          busy_d        = 1'b0;
          ptr_d         = ptr_after_sel;
        end
      end
      ST_ACK: begin
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = ptr_after_sel;
      end
      default: ;
    endcase
  end

  assign ack         = ack_q;
  assign grant       = grant_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
